// File: rtl/sync_gen_pkg.sv
// Shared types and ctrl_word bit positions for the sync generator controller.
package sync_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int CTRL_ARM_BIT    = 0;
  localparam int CTRL_MODE_BIT   = 1;
  localparam int CTRL_FORCE_BIT  = 2;
  localparam int CTRL_STOP_BIT   = 3;
  localparam int CTRL_PERIOD_LSB = 8;

endpackage

// File: rtl/sync_gen_edge_det.sv
// ext_pps synchronizer chain followed by a registered rising-edge detector.
module sync_gen_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;
  logic              rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    hist_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~hist_q;
  end

  // NOTE: flops take <= so every stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/sync_gen_ctrl.sv
// Sync pulse controller: arm on a PPS edge, one-shot or periodic sync generation.
// Optional macro SYNC_GEN_CTRL_PPS_TIMEOUT_EN adds the pps_timeout output.
module sync_gen_ctrl
  import sync_gen_pkg::*;
#(
  parameter int PERIOD_W        = 24,
  parameter int SYNC_WIDTH      = 1,
  parameter int PPS_SYNC_STAGES = 2
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic [31:0] ctrl_word,
  input  logic        ext_pps,
  output logic        sync_out,
  output logic        armed,
  output logic        running,
`ifdef SYNC_GEN_CTRL_PPS_TIMEOUT_EN
  output logic        pps_timeout,
`endif
  output logic [31:0] sync_count
);

  state_e              state_q, state_d;
  logic [31:0]         ctrl_q, ctrl_d;
  logic [3:0]          prev_q, prev_d;
  logic                primed_q, primed_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [7:0]          rem_q, rem_d;
  logic                sync_out_q, sync_out_d;
  logic [31:0]         sync_count_q, sync_count_d;

  logic                pps_evt;
  logic                arm_edge, force_edge, stop_edge, mode;
  logic                sync_evt;
  logic [PERIOD_W-1:0] period_f, reload;
  logic                ctrl_unused;

`ifdef SYNC_GEN_CTRL_PPS_TIMEOUT_EN
  localparam int TMO_W = 28;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_flag_q, tmo_flag_d;
`endif

  sync_gen_edge_det #(.STAGES(PPS_SYNC_STAGES)) u_pps_det (
    .clk  (user_clk),
    .rst  (user_rst),
    .din  (ext_pps),
    .rise (pps_evt)
  );

  assign arm_edge   = ctrl_q[CTRL_ARM_BIT]   & ~prev_q[CTRL_ARM_BIT];
  assign force_edge = ctrl_q[CTRL_FORCE_BIT] & ~prev_q[CTRL_FORCE_BIT];
  assign stop_edge  = ctrl_q[CTRL_STOP_BIT]  & ~prev_q[CTRL_STOP_BIT];
  assign mode       = ctrl_q[CTRL_MODE_BIT];
  assign period_f   = ctrl_q[CTRL_PERIOD_LSB +: PERIOD_W];
  assign reload     = (period_f < PERIOD_W'(2)) ? PERIOD_W'(1) : period_f - PERIOD_W'(1);
  assign ctrl_unused = ^{ctrl_q, prev_q};

  // Force, PPS-in-ARMED and counter expiry merge into a single event.
  assign sync_evt = force_edge
                  | ((state_q == ST_ARMED) & pps_evt)
                  | ((state_q == ST_RUN) & (cnt_q == '0));

  // NOTE: every _d gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_word;
    // Until primed, history tracks the raw input so levels held across reset never look like edges.
    prev_d       = primed_q ? ctrl_q[3:0] : ctrl_word[3:0];
    primed_d     = 1'b1;
    cnt_d        = '0;
    rem_d        = rem_q;
    sync_out_d   = 1'b0;
    sync_count_d = sync_count_q;
`ifdef SYNC_GEN_CTRL_PPS_TIMEOUT_EN
    tmo_flag_d   = arm_edge ? 1'b0 : tmo_flag_q;
`endif

    case (state_q)
      ST_IDLE:  if (arm_edge) state_d = ST_ARMED;
      ST_ARMED: begin
        if (stop_edge)    state_d = ST_IDLE;
        else if (pps_evt) state_d = mode ? ST_RUN : ST_IDLE;
`ifdef SYNC_GEN_CTRL_PPS_TIMEOUT_EN
        else if (tmo_q == '1) begin
          state_d    = ST_IDLE;
          tmo_flag_d = 1'b1;
        end
`endif
      end
      ST_RUN:   if (stop_edge) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (state_d == ST_RUN) cnt_d = sync_evt ? reload : cnt_q - PERIOD_W'(1);

    if (sync_evt) begin
      sync_out_d   = 1'b1;
      rem_d        = 8'(SYNC_WIDTH - 1);
      sync_count_d = sync_count_q + 32'd1;
    end else if (rem_q != '0) begin
      sync_out_d   = 1'b1;
      rem_d        = rem_q - 8'd1;
    end

`ifdef SYNC_GEN_CTRL_PPS_TIMEOUT_EN
    tmo_d = ((state_q == ST_ARMED) && (state_d == ST_ARMED)) ? tmo_q + TMO_W'(1) : '0;
`endif
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q      <= ST_IDLE;
      ctrl_q       <= '0;
      prev_q       <= '0;
      primed_q     <= 1'b0;
      cnt_q        <= '0;
      rem_q        <= '0;
      sync_out_q   <= 1'b0;
      sync_count_q <= '0;
`ifdef SYNC_GEN_CTRL_PPS_TIMEOUT_EN
      tmo_q        <= '0;
      tmo_flag_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      prev_q       <= prev_d;
      primed_q     <= primed_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      sync_out_q   <= sync_out_d;
      sync_count_q <= sync_count_d;
`ifdef SYNC_GEN_CTRL_PPS_TIMEOUT_EN
      tmo_q        <= tmo_d;
      tmo_flag_q   <= tmo_flag_d;
`endif
    end
  end

  assign sync_out   = sync_out_q;
  assign armed      = (state_q == ST_ARMED);
  assign running    = (state_q == ST_RUN);
  assign sync_count = sync_count_q;
`ifdef SYNC_GEN_CTRL_PPS_TIMEOUT_EN
  assign pps_timeout = tmo_flag_q;
`endif

endmodule

// File: tb/tb_sync_gen_ctrl.sv
// Self-checking bench for sync_gen_ctrl: table of periodic runs plus corner-case sequences,
// with expected sync pulse cycles held in a scoreboard queue.
module tb_sync_gen_ctrl;

  typedef struct {
    logic [23:0] period;
    int          interval;
    int          pulses;
  } vec_t;

  logic        user_clk = 1'b0;
  logic        user_rst;
  logic [31:0] ctrl_word;
  logic        ext_pps;
  logic        sync_out1, armed1, running1;
  logic [31:0] sync_count1;
  logic        sync_out4, armed4, running4;
  logic [31:0] sync_count4;
`ifdef SYNC_GEN_CTRL_PPS_TIMEOUT_EN
  logic        pps_timeout1, pps_timeout4;
`endif

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  int          exp_q[$];
  int          w4_last = -100;
  logic [31:0] prev_cnt = '0;

  sync_gen_ctrl dut (
    .user_clk   (user_clk),
    .user_rst   (user_rst),
    .ctrl_word  (ctrl_word),
    .ext_pps    (ext_pps),
    .sync_out   (sync_out1),
    .armed      (armed1),
    .running    (running1),
`ifdef SYNC_GEN_CTRL_PPS_TIMEOUT_EN
    .pps_timeout(pps_timeout1),
`endif
    .sync_count (sync_count1)
  );

  sync_gen_ctrl #(.SYNC_WIDTH(4)) dut_w4 (
    .user_clk   (user_clk),
    .user_rst   (user_rst),
    .ctrl_word  (ctrl_word),
    .ext_pps    (ext_pps),
    .sync_out   (sync_out4),
    .armed      (armed4),
    .running    (running4),
`ifdef SYNC_GEN_CTRL_PPS_TIMEOUT_EN
    .pps_timeout(pps_timeout4),
`endif
    .sync_count (sync_count4)
  );

  always #5 user_clk = ~user_clk;
  always @(posedge user_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: a sync pulse must appear exactly on each queued cycle and nowhere else.
  always @(negedge user_clk) begin
    logic exp_evt;
    if (mon_en) begin
      exp_evt = (exp_q.size() > 0) && (exp_q[0] == cyc);
      if (exp_evt) begin
        void'(exp_q.pop_front());
        w4_last = cyc;
      end
      check("sync_count step", sync_count1 - prev_cnt, 32'(exp_evt));
      check("sync_out width1", 32'(sync_out1), 32'(exp_evt));
      check("sync_out width4", 32'(sync_out4), 32'((cyc - w4_last) < 4));
    end
    prev_cnt = sync_count1;
  end

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge user_clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [31:0] ctrl_init);
    mon_en    = 1'b0;
    exp_q.delete();
    user_rst  = 1'b1;
    ctrl_word = ctrl_init;
    ext_pps   = 1'b0;
    @(posedge user_clk); #1;
    check("reset sync_out", 32'(sync_out1), 32'd0);
    check("reset armed", 32'(armed1), 32'd0);
    check("reset running", 32'(running1), 32'd0);
    check("reset sync_count", sync_count1, 32'd0);
    check("reset sync_out w4", 32'(sync_out4), 32'd0);
    @(posedge user_clk); #1;
    user_rst = 1'b0;
    w4_last  = -100;
    @(posedge user_clk); #1;
    mon_en = 1'b1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   a, n, s, f;
    vec_t vecs[6];
    vecs[0] = '{24'd10, 10, 4};
    vecs[1] = '{24'd0,  2,  4};
    vecs[2] = '{24'd1,  2,  4};
    vecs[3] = '{24'd2,  2,  3};
    vecs[4] = '{24'd3,  3,  4};
    vecs[5] = '{24'd7,  7,  3};

    // Arm bit held high through reset must not arm; a fresh 0->1 edge must.
    do_reset(32'h1);
    wait_to(cyc + 5);
    check("arm held through reset", 32'(armed1), 32'd0);
    a = cyc;
    ctrl_word = 32'h0;
    wait_to(a + 2);
    ctrl_word = 32'h1;
    wait_to(a + 4);
    check("armed after arm edge", 32'(armed1), 32'd1);

    // One-shot: pps edge driven in cycle n, pulse at n+4, back to IDLE.
    wait_to(a + 6);
    ext_pps = 1'b1;
    n = cyc;
    exp_q.push_back(n + 4);
    wait_to(n + 2);
    ext_pps = 1'b0;
    wait_to(n + 3);
    check("armed until pps event", 32'(armed1), 32'd1);
    wait_to(n + 8);
    check("one-shot armed", 32'(armed1), 32'd0);
    check("one-shot running", 32'(running1), 32'd0);
    check("one-shot sync_count", sync_count1, 32'd1);

    // Periodic table: stop edge lands on the cycle of the last expiry.
    for (int i = 0; i < 6; i++) begin
      do_reset(32'h0);
      a = cyc + 1;
      wait_to(a);
      ctrl_word = {vecs[i].period, 8'h03};
      wait_to(a + 2);
      check("table armed", 32'(armed1), 32'd1);
      wait_to(a + 4);
      ext_pps = 1'b1;
      n = cyc;
      for (int k = 0; k < vecs[i].pulses; k++) exp_q.push_back(n + 4 + k * vecs[i].interval);
      s = n + 3 + (vecs[i].pulses - 1) * vecs[i].interval - 1;
      wait_to(n + 2);
      ext_pps = 1'b0;
      wait_to(n + 5);
      check("table running", 32'(running1), 32'd1);
      check("table armed in run", 32'(armed1), 32'd0);
      wait_to(s);
      ctrl_word = {vecs[i].period, 8'h0B};
      wait_to(s + 3 * vecs[i].interval + 6);
      check("table running after stop", 32'(running1), 32'd0);
      check("table armed after stop", 32'(armed1), 32'd0);
      check("table sync_count", sync_count1, 32'(vecs[i].pulses));
      check("table scoreboard drained", 32'(exp_q.size()), 32'd0);
    end

    // Force edge coincident with pps in ARMED: exactly one event.
    do_reset(32'h0);
    a = cyc + 1;
    wait_to(a);
    ctrl_word = 32'h1;
    wait_to(a + 3);
    ext_pps = 1'b1;
    n = cyc;
    exp_q.push_back(n + 4);
    wait_to(n + 2);
    ext_pps   = 1'b0;
    ctrl_word = 32'h5;
    wait_to(n + 10);
    check("force+pps sync_count", sync_count1, 32'd1);
    check("force+pps armed", 32'(armed1), 32'd0);
    check("force+pps running", 32'(running1), 32'd0);

    // RUN with P=5: force on expiry, force mid-count, period change at next reload, stop on expiry.
    do_reset(32'h0);
    a = cyc + 1;
    wait_to(a);
    ctrl_word = 32'h0503;
    wait_to(a + 3);
    ext_pps = 1'b1;
    n = cyc;
    exp_q.push_back(n + 4);
    exp_q.push_back(n + 9);
    exp_q.push_back(n + 11);
    exp_q.push_back(n + 16);
    exp_q.push_back(n + 19);
    exp_q.push_back(n + 22);
    wait_to(n + 2);
    ext_pps = 1'b0;
    wait_to(n + 7);
    ctrl_word = 32'h0507;
    wait_to(n + 8);
    ctrl_word = 32'h0503;
    wait_to(n + 9);
    ctrl_word = 32'h0507;
    wait_to(n + 11);
    ctrl_word = 32'h0303;
    wait_to(n + 20);
    ctrl_word = 32'h030B;
    wait_to(n + 35);
    check("force run running", 32'(running1), 32'd0);
    check("force run sync_count", sync_count1, 32'd6);

    // Force in IDLE issues an event without changing state.
    f = cyc;
    ctrl_word = 32'h4;
    exp_q.push_back(f + 2);
    wait_to(f + 6);
    check("idle force sync_count", sync_count1, 32'd7);
    check("idle force armed", 32'(armed1), 32'd0);
    check("idle force running", 32'(running1), 32'd0);

    // Counter wrap from 0xFFFFFFFF.
    mon_en = 1'b0;
    force dut.sync_count_q = 32'hFFFF_FFFF;
    @(posedge user_clk); #1;
    release dut.sync_count_q;
    @(posedge user_clk); #1;
    check("preload sync_count", sync_count1, 32'hFFFF_FFFF);
    mon_en = 1'b1;
    f = cyc;
    ctrl_word = 32'h0;
    wait_to(f + 1);
    ctrl_word = 32'h4;
    exp_q.push_back(f + 3);
    wait_to(f + 6);
    check("sync_count wrap", sync_count1, 32'd0);

    // Asynchronous reset in the middle of a RUN pulse train.
    do_reset(32'h0);
    a = cyc + 1;
    wait_to(a);
    ctrl_word = 32'h0303;
    wait_to(a + 3);
    ext_pps = 1'b1;
    n = cyc;
    exp_q.push_back(n + 4);
    exp_q.push_back(n + 7);
    exp_q.push_back(n + 10);
    wait_to(n + 2);
    ext_pps = 1'b0;
    wait_to(n + 11);
    check("w4 high before reset", 32'(sync_out4), 32'd1);
    check("running before reset", 32'(running1), 32'd1);
    mon_en = 1'b0;
    #2;
    user_rst = 1'b1;
    #1;
    check("async rst sync_out", 32'(sync_out1), 32'd0);
    check("async rst sync_out w4", 32'(sync_out4), 32'd0);
    check("async rst running", 32'(running1), 32'd0);
    check("async rst armed", 32'(armed1), 32'd0);
    check("async rst sync_count", sync_count1, 32'd0);
    check("async rst running w4", 32'(running4), 32'd0);
    check("async rst sync_count w4", sync_count4, 32'd0);
    check("async rst scoreboard", 32'(exp_q.size()), 32'd0);
    @(posedge user_clk); #1;
    @(posedge user_clk); #1;
    user_rst = 1'b0;
    w4_last  = -100;
    @(posedge user_clk); #1;
    mon_en = 1'b1;
    wait_to(cyc + 8);
    check("arm held across reset", 32'(armed1), 32'd0);
    check("running after reset", 32'(running1), 32'd0);
    check("armed w4 after reset", 32'(armed4), 32'd0);
    check("final scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_gen_ctrl.md
SYNC_GEN_CTRL -- requirements
Module: sync_gen_ctrl

Interface
REQ-001 Parameter PERIOD_W, default 24, width of the period field in ctrl_word.
REQ-002 Parameter SYNC_WIDTH, default 1, sync_out pulse length in cycles (1..255).
REQ-003 Parameter PPS_SYNC_STAGES, default 2, synchronizer depth on ext_pps (2..4).
REQ-004 user_clk  in  1  sole clock; all logic rising-edge.
REQ-005 user_rst  in  1  asynchronous, active-high reset.
REQ-006 ctrl_word  in  32  software register value; bit0 arm, bit1 periodic mode, bit2 force, bit3 stop, bits[8 +: PERIOD_W] period.
REQ-007 ext_pps  in  1  external 1PPS, asynchronous to user_clk.
REQ-008 sync_out  out  1  sync pulse to the downstream datapath.
REQ-009 armed  out  1  high in state ARMED.
REQ-010 running  out  1  high in state RUN.
REQ-011 sync_count  out  32  number of sync events issued since reset, wraps 0xFFFFFFFF->0.

Function
REQ-012 ctrl_word SHALL be registered once; arm/force/stop actions SHALL fire on the 0->1 edge of the registered bit, one action per edge.
REQ-013 ext_pps SHALL pass PPS_SYNC_STAGES flops, then rising-edge detect; pps event SHALL occur PPS_SYNC_STAGES+1 cycles after the input edge.
REQ-014 States IDLE, ARMED, RUN; IDLE --arm--> ARMED; ARMED --pps, mode=0--> IDLE; ARMED --pps, mode=1--> RUN; ARMED/RUN --stop--> IDLE.
REQ-015 A pps event in ARMED SHALL issue a sync event in the same cycle it is detected.
REQ-016 In RUN a down-counter SHALL load P-1 at each sync event and issue the next sync event on reaching 0; P = max(period field, 2).
REQ-017 Force SHALL issue a sync event in any state; in RUN it SHALL reload the counter; it SHALL NOT change state.
REQ-018 Simultaneous force and pps, or force and counter expiry, SHALL produce exactly one sync event.
REQ-019 Stop in the same cycle as a sync trigger: the sync event SHALL issue, then state becomes IDLE.
REQ-020 arm edge while ARMED or RUN SHALL be ignored; pps in IDLE or RUN SHALL be ignored.
REQ-021 Each sync event SHALL drive sync_out high for SYNC_WIDTH cycles starting the cycle after the event; a new event during the pulse SHALL restart the width count.
REQ-022 sync_count SHALL increment by 1 per sync event, registered with sync_out.
REQ-023 Period field changes SHALL take effect at the next counter reload.

Reset
REQ-024 On user_rst: state IDLE, sync_out 0, armed 0, running 0, sync_count 0, counter 0, synchronizer and edge-history flops 0.
REQ-025 Reset mid-pulse SHALL drop sync_out immediately; after release a ctrl bit already high SHALL NOT fire until it returns low and high again.

Configuration
REQ-026 Macro SYNC_GEN_CTRL_PPS_TIMEOUT_EN: when defined, output pps_timeout (1 bit) is added; ARMED with no pps for 2^28 cycles SHALL return to IDLE and set pps_timeout, cleared on next arm edge or reset.
REQ-027 Without the macro, ARMED waits indefinitely and pps_timeout does not exist.

Structure
REQ-028 Package sync_gen_pkg SHALL hold the state enum and ctrl_word bit-position constants.
REQ-029 Sub-module sync_gen_edge_det SHALL implement the ext_pps synchronizer plus rising-edge detect.

Verification
REQ-030 Arm (ctrl 0x1), ext_pps edge at cycle 100 -> single sync_out pulse at cycle 104 (stages=2), state IDLE, sync_count=1.
REQ-031 ctrl 0x0000_0A03 then pps -> pulses every 10 cycles; stop edge -> no further pulses, running=0.
REQ-032 Periodic, period field 0 or 1 -> pulses every 2 cycles.
REQ-033 Force edge coincident with pps in ARMED -> exactly one pulse, sync_count +1.
REQ-034 SYNC_WIDTH=4, period 3 -> sync_out stays high continuously while count increments every 3 cycles.
REQ-035 Preload sync_count 0xFFFFFFFF (force) -> next event gives 0; assert user_rst mid-RUN -> all outputs 0 asynchronously.
